// File: rtl/mybusmatrix5x7_in_hold.sv
// ---------------------------------------------------------------------------
// mybusmatrix5x7_in_hold
//
// Per-master input stage of the 5x7 bus matrix. One instance sits in front of
// each master port. When the slave-side output stage cannot take this master's
// address phase right away, the transfer is parked in a one-entry holding
// register and the master is stalled until the grant arrives.
//
// Handshake: a master address phase completes on a rising edge where HSELS,
// HTRANSS[1] and HREADYS are all high (new_trans). The output stage accepts
// the presented address when addr_in_phase and HREADYM_i are both high on the
// same edge; if it does not, the transfer is captured here and HREADYOUTS is
// held low until acceptance.
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSELS..HMASTLOCKS     master address-phase inputs
//   HREADYS               bus-wide HREADY seen by the master
//   addr_in_phase         output stage grants this port's address phase
//   data_in_phase         output stage runs this port's data phase
//   HREADYM_i, HRESPM_i   ready/response returned through the output stage
//   sel_int..lock_int     address-phase fields towards decoder/arbiters
//   HREADYOUTS, HRESPS    ready/response to the master
// ---------------------------------------------------------------------------
module mybusmatrix5x7_in_hold (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic [2:0]  HBURSTS,
    input  logic [3:0]  HPROTS,
    input  logic        HMASTLOCKS,
    input  logic        HREADYS,
    input  logic        addr_in_phase,
    input  logic        data_in_phase,
    input  logic        HREADYM_i,
    input  logic        HRESPM_i,
    output logic        sel_int,
    output logic [1:0]  trans_int,
    output logic [31:0] addr_int,
    output logic        write_int,
    output logic [2:0]  size_int,
    output logic [2:0]  burst_int,
    output logic [3:0]  prot_int,
    output logic        lock_int,
    output logic        HREADYOUTS,
    output logic        HRESPS
);

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_trans;
    logic        r_write;
    logic [2:0]  r_size;
    logic [2:0]  r_burst;
    logic [3:0]  r_prot;
    logic        r_lock;

    logic w_new_trans;
    logic w_hold;

    assign w_new_trans = HSELS & HTRANSS[1] & HREADYS;

    // Reset forces the pass-through view immediately, even in the cycle
    // before the reset edge has cleared a held transfer.
    assign w_hold = (r_state == HOLD) & ~HRESET;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= PASS;
            r_addr  <= '0;
            r_trans <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_burst <= '0;
            r_prot  <= '0;
            r_lock  <= 1'b0;
        end else begin
            case (r_state)
                PASS: begin
                    // Park the transfer only if the output stage did not
                    // take it on this very edge.
                    if (w_new_trans && (!addr_in_phase || !HREADYM_i)) begin
                        r_state <= HOLD;
                        r_addr  <= HADDRS;
                        r_trans <= HTRANSS;
                        r_write <= HWRITES;
                        r_size  <= HSIZES;
                        r_burst <= HBURSTS;
                        r_prot  <= HPROTS;
                        r_lock  <= HMASTLOCKS;
                    end
                end
                HOLD: begin
                    // The master is stalled here, so HREADYS is low and no
                    // new transfer can coincide with this exit edge.
                    if (addr_in_phase && HREADYM_i) begin
                        r_state <= PASS;
                    end
                end
                default: r_state <= PASS;
            endcase
        end
    end

    assign sel_int   = w_hold ? 1'b1    : (HSELS & HTRANSS[1]);
    assign trans_int = w_hold ? r_trans : HTRANSS;
    assign addr_int  = w_hold ? r_addr  : HADDRS;
    assign write_int = w_hold ? r_write : HWRITES;
    assign size_int  = w_hold ? r_size  : HSIZES;
    assign burst_int = w_hold ? r_burst : HBURSTS;
    assign prot_int  = w_hold ? r_prot  : HPROTS;
    assign lock_int  = w_hold ? r_lock  : HMASTLOCKS;

    assign HREADYOUTS = w_hold ? 1'b0 : (data_in_phase ? HREADYM_i : 1'b1);
    assign HRESPS     = data_in_phase ? HRESPM_i : 1'b0;

endmodule

// File: tb/tb_mybusmatrix5x7_in_hold.sv
module tb_mybusmatrix5x7_in_hold;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        addr_in_phase;
    logic        data_in_phase;
    logic        HREADYM_i;
    logic        HRESPM_i;
    logic        sel_int;
    logic [1:0]  trans_int;
    logic [31:0] addr_int;
    logic        write_int;
    logic [2:0]  size_int;
    logic [2:0]  burst_int;
    logic [3:0]  prot_int;
    logic        lock_int;
    logic        HREADYOUTS;
    logic        HRESPS;

    int vectors = 0;
    int errs    = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    // clock / reset
    always #5 HCLK = ~HCLK;

    mybusmatrix5x7_in_hold dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HSELS         (HSELS),
        .HADDRS        (HADDRS),
        .HTRANSS       (HTRANSS),
        .HWRITES       (HWRITES),
        .HSIZES        (HSIZES),
        .HBURSTS       (HBURSTS),
        .HPROTS        (HPROTS),
        .HMASTLOCKS    (HMASTLOCKS),
        .HREADYS       (HREADYS),
        .addr_in_phase (addr_in_phase),
        .data_in_phase (data_in_phase),
        .HREADYM_i     (HREADYM_i),
        .HRESPM_i      (HRESPM_i),
        .sel_int       (sel_int),
        .trans_int     (trans_int),
        .addr_int      (addr_int),
        .write_int     (write_int),
        .size_int      (size_int),
        .burst_int     (burst_int),
        .prot_int      (prot_int),
        .lock_int      (lock_int),
        .HREADYOUTS    (HREADYOUTS),
        .HRESPS        (HRESPS)
    );

    // driver tasks
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_addr(input logic sel, input logic [1:0] trans,
                              input logic [31:0] addr, input logic wr);
        HSELS   = sel;
        HTRANSS = trans;
        HADDRS  = addr;
        HWRITES = wr;
    endtask

    // scoreboard compare
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int idx;
    int hold_entries;
    logic prev_hold;
    logic gap_pending;
    int cyc;

    initial begin
        HRESET = 1'b1;
        drive_addr(1'b1, 2'b10, 32'hAAAA_0000, 1'b0);
        HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
        HREADYS = 1'b1; addr_in_phase = 1'b0; data_in_phase = 1'b0;
        HREADYM_i = 1'b1; HRESPM_i = 1'b0;
        tick();
        tick();
        // outputs during reset follow live inputs, ready/OKAY
        settle();
        chk("rst_ready", {31'd0, HREADYOUTS}, 32'd1);
        chk("rst_resp",  {31'd0, HRESPS}, 32'd0);
        chk("rst_addr",  addr_int, 32'hAAAA_0000);
        chk("rst_sel",   {31'd0, sel_int}, 32'd1);

        // pass-through with immediate grant
        HRESET = 1'b0;
        drive_addr(1'b1, 2'b10, 32'h2000_0000, 1'b0);
        addr_in_phase = 1'b1; HREADYM_i = 1'b1;
        settle();
        chk("pt_addr",  addr_int, 32'h2000_0000);
        chk("pt_ready", {31'd0, HREADYOUTS}, 32'd1);
        tick();
        drive_addr(1'b1, 2'b00, 32'h2000_0004, 1'b0);
        addr_in_phase = 1'b0;
        settle();
        chk("pt_nohold", {31'd0, HREADYOUTS}, 32'd1);
        chk("pt_idle_sel", {31'd0, sel_int}, 32'd0);

        // contention: no grant for three cycles
        drive_addr(1'b1, 2'b10, 32'h4000_0010, 1'b1);
        HSIZES = 3'd2; addr_in_phase = 1'b0;
        settle();
        chk("ct_pre_ready", {31'd0, HREADYOUTS}, 32'd1);
        tick();
        // master is stalled; scramble its pins to show the register is used
        HREADYS = 1'b0;
        drive_addr(1'b0, 2'b00, 32'hDEAD_BEEF, 1'b0);
        for (int c = 0; c < 3; c++) begin
            addr_in_phase = (c == 2);
            settle();
            chk($sformatf("ct_ready_%0d", c), {31'd0, HREADYOUTS}, 32'd0);
            chk($sformatf("ct_addr_%0d", c), addr_int, 32'h4000_0010);
            chk($sformatf("ct_write_%0d", c), {31'd0, write_int}, 32'd1);
            chk($sformatf("ct_trans_%0d", c), {30'd0, trans_int}, 32'd2);
            chk($sformatf("ct_sel_%0d", c), {31'd0, sel_int}, 32'd1);
            tick();
        end
        addr_in_phase = 1'b0;
        HREADYS = 1'b1;
        settle();
        chk("ct_post_ready", {31'd0, HREADYOUTS}, 32'd1);
        chk("ct_post_addr",  addr_int, 32'hDEAD_BEEF);

        // error response through data phase
        drive_addr(1'b1, 2'b00, 32'h0, 1'b0);
        data_in_phase = 1'b1; HRESPM_i = 1'b1; HREADYM_i = 1'b0;
        settle();
        chk("err_resp0",  {31'd0, HRESPS}, 32'd1);
        chk("err_ready0", {31'd0, HREADYOUTS}, 32'd0);
        tick();
        HREADYM_i = 1'b1;
        settle();
        chk("err_resp1",  {31'd0, HRESPS}, 32'd1);
        chk("err_ready1", {31'd0, HREADYOUTS}, 32'd1);
        tick();
        data_in_phase = 1'b0; HRESPM_i = 1'b0;
        settle();
        chk("err_resp_off", {31'd0, HRESPS}, 32'd0);

        // reset while holding a transfer
        drive_addr(1'b1, 2'b10, 32'h1234_5678, 1'b0);
        addr_in_phase = 1'b0;
        tick();
        HREADYS = 1'b0;
        settle();
        chk("rh_ready", {31'd0, HREADYOUTS}, 32'd0);
        chk("rh_addr",  addr_int, 32'h1234_5678);
        HRESET = 1'b1;
        drive_addr(1'b1, 2'b00, 32'h5555_0000, 1'b0);
        settle();
        chk("rh_in_rst_ready", {31'd0, HREADYOUTS}, 32'd1);
        chk("rh_in_rst_addr",  addr_int, 32'h5555_0000);
        tick();
        HRESET = 1'b0;
        HREADYS = 1'b1;
        settle();
        chk("rh_after_ready", {31'd0, HREADYOUTS}, 32'd1);
        chk("rh_after_addr",  addr_int, 32'h5555_0000);
        chk("rh_after_sel",   {31'd0, sel_int}, 32'd0);

        // IDLE then BUSY with no grant must not stall
        for (int t = 0; t < 2; t++) begin
            drive_addr(1'b1, (t == 0) ? 2'b00 : 2'b01, 32'h6000_0000, 1'b1);
            addr_in_phase = 1'b0;
            tick();
            settle();
            chk($sformatf("ib_ready_%0d", t), {31'd0, HREADYOUTS}, 32'd1);
            chk($sformatf("ib_resp_%0d", t),  {31'd0, HRESPS}, 32'd0);
            chk($sformatf("ib_sel_%0d", t),   {31'd0, sel_int}, 32'd0);
        end

        // INCR4 burst with a one-cycle grant gap on beat 3
        for (int b = 0; b < 4; b++) exp_q.push_back(32'h0000_0100 + 32'(b * 4));
        idx = 0; hold_entries = 0; prev_hold = 1'b0; gap_pending = 1'b1; cyc = 0;
        HBURSTS = 3'd3; HREADYM_i = 1'b1;
        while (idx < 4 && cyc < 20) begin
            drive_addr(1'b1, (idx == 0) ? 2'b10 : 2'b11, 32'h0000_0100 + 32'(idx * 4), 1'b0);
            addr_in_phase = !(idx == 2 && gap_pending);
            settle();
            HREADYS = HREADYOUTS;
            settle();
            if (addr_in_phase && HREADYM_i && sel_int) got_q.push_back(addr_int);
            if (!HREADYOUTS && !prev_hold) hold_entries++;
            prev_hold = !HREADYOUTS;
            if (idx == 2 && !addr_in_phase) gap_pending = 1'b0;
            @(posedge HCLK);
            if (HREADYS) idx++;
            #1;
            cyc++;
        end
        drive_addr(1'b0, 2'b00, 32'h0, 1'b0);
        HREADYS = 1'b1; addr_in_phase = 1'b0;
        chk("bb_done_in_budget", {31'd0, idx == 4}, 32'd1);
        chk("bb_hold_entries", 32'(hold_entries), 32'd1);
        chk("bb_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (got_q.size() > 0) chk("bb_addr", got_q.pop_front(), e);
            else chk("bb_addr_missing", 32'hFFFF_FFFF, e);
        end
        tick();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/mybusmatrix5x7_in_hold.md
MYBUSMATRIX5X7_IN_HOLD -- requirements
Module: mybusmatrix5x7_in_hold

Interface
REQ-001 The block SHALL be the per-master input stage feeding the slave-side output arbiters, one instance per master port; clock HCLK, synchronous active-high reset HRESET.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- HCLK  in  1  AHB clock, all state on rising edge
- HRESET  in  1  synchronous active-high reset
- HSELS  in  1  master-side select
- HADDRS  in  32  address
- HTRANSS  in  2  transfer type
- HWRITES  in  1  write
- HSIZES  in  3  size
- HBURSTS  in  3  burst
- HPROTS  in  4  protection
- HMASTLOCKS  in  1  lock
- HREADYS  in  1  bus-wide HREADY seen by the master
- addr_in_phase  in  1  output stage has granted this port's address phase
- data_in_phase  in  1  output stage is running this port's data phase
- HREADYM_i  in  1  HREADY returned through the output stage
- HRESPM_i  in  1  HRESP returned through the output stage
- sel_int, trans_int[1:0], addr_int[31:0], write_int, size_int[2:0], burst_int[2:0], prot_int[3:0], lock_int  out  address-phase fields presented to decoder/arbiters
- HREADYOUTS  out  1  ready to master
- HRESPS  out  1  response to master

Function
REQ-003 new_trans SHALL be HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ sampled at end of master address phase).
REQ-004 The block SHALL implement two states: PASS (holding register empty) and HOLD (one transfer stored).
REQ-005 In PASS, *_int outputs SHALL equal the live master inputs combinationally; sel_int = HSELS & HTRANSS[1].
REQ-006 In HOLD, *_int outputs SHALL come from the holding register, sel_int=1, trans_int = stored HTRANSS.
REQ-007 PASS->HOLD SHALL occur on a rising edge where new_trans=1 and (addr_in_phase=0 or HREADYM_i=0); all address fields SHALL be captured on that edge.
REQ-008 HOLD->PASS SHALL occur on a rising edge where addr_in_phase=1 and HREADYM_i=1; no other event SHALL leave HOLD.
REQ-009 While in HOLD, the holding register SHALL NOT be overwritten; no new transfer can arrive because REQ-010 stalls the master.
REQ-010 HREADYOUTS SHALL be 0 in HOLD; HREADYM_i when data_in_phase=1; otherwise 1.
REQ-011 HRESPS SHALL be HRESPM_i when data_in_phase=1 and 0 (OKAY) otherwise.
REQ-012 IDLE or BUSY transfers (HTRANSS[1]=0) SHALL never enter HOLD and SHALL get a zero-wait OKAY response from the block.
REQ-013 With new_trans=1, addr_in_phase=1 and HREADYM_i=1 on the same edge, the block SHALL stay in PASS (zero-latency pass-through).
REQ-014 The HOLD->PASS edge and a new_trans sample SHALL NOT coincide, because HREADYS=0 while in HOLD; the block needs no extra logic for this case.
REQ-015 Latency SHALL be 0 cycles in PASS and 1 cycle per grant-wait cycle in HOLD; the held-transfer data phase SHALL start the cycle after the HOLD->PASS edge.

Reset
REQ-016 With HRESET=1 at a rising edge, the state SHALL become PASS and all holding-register fields SHALL be 0; this applies mid-HOLD and discards the held transfer.
REQ-017 While in reset, the outputs SHALL be HREADYOUTS=1, HRESPS=0, and *_int equal to the live inputs per REQ-005.

Verification
REQ-018 Pass-through: NONSEQ to 0x2000_0000 with addr_in_phase=1, HREADYM_i=1 -> addr_int=0x2000_0000 in the same cycle, no HOLD, HREADYOUTS=1.
REQ-019 Contention: NONSEQ write to 0x4000_0010 with addr_in_phase=0 for 3 cycles, then 1 -> HOLD for 3 cycles, addr_int stable at 0x4000_0010, HREADYOUTS=0 for 3 cycles, then PASS.
REQ-020 Error response: data_in_phase=1 with HRESPM_i=1 and HREADYM_i 0 then 1 -> HRESPS=1 for both cycles, HREADYOUTS 0 then 1.
REQ-021 Reset mid-HOLD: HRESET=1 for 1 cycle while holding 0x1234_5678 -> PASS, addr held register 0, HREADYOUTS=1.
REQ-022 IDLE/BUSY with HSELS=1 and addr_in_phase=0 -> no HOLD entry, HREADYOUTS=1, HRESPS=0.
REQ-023 Back-to-back: SEQ bursts of 4 with a grant gap on beat 3 -> exactly one HOLD entry, and addresses are presented in order with none dropped or duplicated.
